// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style main control unit: a Moore FSM that sequences fetch,
// decode and the per-class execute steps, and counts retired instructions.
module multicycle_ctrl (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        pc_write_cond,
   output logic        i_or_d,
   output logic        mem_read,
   output logic        mem_write,
   output logic        ir_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        illegal_op,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   state_e      state_q, state_d;
   logic [31:0] instr_count_q, instr_count_d;
   logic        retire;
   logic        zero_unused;

   // The zero flag is combined with pc_write_cond by the datapath's PC enable.
   assign zero_unused = zero;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEM_ADDR;
               OP_RTYPE:     state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDI_EXEC;
               default:      state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_EXECUTE:   state_d = S_R_WB;
         S_R_WB:      state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_ADDI_EXEC: state_d = S_ADDI_WB;
         S_ADDI_WB:   state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   // An instruction retires on the edge that leaves its last state.
   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: retire = 1'b1;
         S_MEM_WRITE:                                    retire = mem_ready;
         default:                                        retire = 1'b0;
      endcase
      instr_count_d = retire ? instr_count_q + 32'd1 : instr_count_q;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q       <= S_FETCH;
         instr_count_q <= 32'd0;
      end else begin
         state_q       <= state_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 3'b000;
      pc_source     = 2'b00;
      illegal_op    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
               default:                                       illegal_op = 1'b1;
            endcase
         end
         S_MEM_ADDR, S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b010;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 3'b001;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_ADDI_WB: reg_write = 1'b1;
         default: ;
      endcase
      // Reset must silence every architectural write strobe, even in FETCH.
      if (Rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_write     = 1'b0;
         illegal_op    = 1'b0;
      end
   end

   assign state       = state_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed scenarios plus random instruction streams
// checked cycle by cycle against a per-instruction state-path reference model.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0]  alu_src_b, pc_source;
   logic [2:0]  alu_op;
   logic [3:0]  state;
   logic [31:0] instr_count;

   multicycle_ctrl dut (
      .Clk(Clk), .Rst(Rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
      .instr_count(instr_count)
   );

   always #5 Clk = ~Clk;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          path[$];
   int          idx;
   int          cyc;
   int          stalls;
   int          stall_left;
   bit          cur_legal;
   bit          cur_zero;
   bit          instr_done;
   logic [5:0]  cur_op;
   logic [31:0] exp_count;
   int          obs_mw, obs_rw, obs_ill, obs_pcc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Control word each state is required to drive.
   function automatic logic [17:0] exp_ctrl(input int st, input bit rdy, input bit ill);
      logic pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa, il;
      logic [1:0] asb, pcs;
      logic [2:0] aop;
      {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa, il} = '0;
      asb = 2'b00; pcs = 2'b00; aop = 3'b000;
      case (st)
         0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
         1:  begin asb = 2'b11; il = ill; end
         2:  begin asa = 1; asb = 2'b10; end
         3:  begin mr = 1; iod = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; iod = 1; end
         6:  begin asa = 1; aop = 3'b010; end
         7:  begin rw = 1; rd = 1; end
         8:  begin asa = 1; aop = 3'b001; pcc = 1; pcs = 2'b01; end
         9:  begin pcw = 1; pcs = 2'b10; end
         10: begin asa = 1; asb = 2'b10; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw, pcc, iod, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, il};
   endfunction

   function automatic int base_latency(input logic [5:0] op);
      case (op)
         OP_LW:                      return 5;
         OP_SW, OP_RTYPE, OP_ADDI:   return 4;
         OP_BEQ, OP_J:               return 3;
         default:                    return 2;
      endcase
   endfunction

   task automatic begin_instr(input logic [5:0] op, input bit z);
      cur_op = op; cur_zero = z; cur_legal = 1'b1;
      path.delete();
      path.push_back(0); path.push_back(1);
      case (op)
         OP_LW:    begin path.push_back(2); path.push_back(3); path.push_back(4); end
         OP_SW:    begin path.push_back(2); path.push_back(5); end
         OP_RTYPE: begin path.push_back(6); path.push_back(7); end
         OP_BEQ:   path.push_back(8);
         OP_J:     path.push_back(9);
         OP_ADDI:  begin path.push_back(10); path.push_back(11); end
         default:  cur_legal = 1'b0;
      endcase
      idx = 0; cyc = 0; stalls = 0; instr_done = 1'b0;
      obs_mw = 0; obs_rw = 0; obs_ill = 0; obs_pcc = 0;
   endtask

   task automatic step_cycle(input bit rdy);
      int st;
      @(negedge Clk);
      st = path[idx];
      opcode = cur_op; zero = cur_zero; mem_ready = rdy;
      #1;
      chk("state", {28'd0, state}, st);
      chk("ctrl", {14'd0, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op},
          {14'd0, exp_ctrl(st, rdy, (st == 1) && !cur_legal)});
      chk("count", instr_count, exp_count);
      chk("excl_wr", (int'(reg_write) + int'(mem_write) + int'(ir_write)) > 1, 0);
      obs_mw += int'(mem_write); obs_rw += int'(reg_write);
      obs_ill += int'(illegal_op); obs_pcc += int'(pc_write_cond);
      cyc++;
      if ((st == 0 || st == 3 || st == 5) && !rdy) stalls++;
      else idx++;
      if (idx == path.size()) begin
         if (cur_legal) exp_count = exp_count + 32'd1;
         instr_done = 1'b1;
      end
   endtask

   // mode 0: always ready; 1: random ready; 2: stall_left stalls in MEM_WRITE
   task automatic finish_instr(input int mode);
      bit rdy;
      while (!instr_done && cyc < 100) begin
         case (mode)
            0: rdy = 1'b1;
            1: rdy = ($urandom_range(0, 3) != 0);
            default: begin
               if (path[idx] == 5 && stall_left > 0) begin rdy = 1'b0; stall_left--; end
               else rdy = 1'b1;
            end
         endcase
         step_cycle(rdy);
      end
      chk("done", {31'd0, instr_done}, 1);
      chk("latency", cyc, base_latency(cur_op) + stalls);
   endtask

   task automatic run_instr(input logic [5:0] op, input bit z, input int mode);
      begin_instr(op, z);
      finish_instr(mode);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_state"}, {28'd0, state}, 0);
      chk({tag, "_count"}, instr_count, 0);
      chk({tag, "_strobes"}, {27'd0, pc_write, pc_write_cond, ir_write, reg_write, mem_write}, 0);
      chk({tag, "_ill"}, {31'd0, illegal_op}, 0);
   endtask

   initial begin
      logic [5:0] op;
      logic [31:0] cnt_before;
      Rst = 1'b1; opcode = OP_LW; zero = 1'b0; mem_ready = 1'b1;
      exp_count = 32'd0;
      #1;
      check_reset_outputs("rst0");
      @(posedge Clk); #1;
      check_reset_outputs("rst1");
      @(negedge Clk);
      Rst = 1'b0; mem_ready = 1'b0;

      // lw with no stalls: path 0,1,2,3,4 and a single reg_write
      run_instr(OP_LW, 1'b0, 0);
      chk("lw_regwrite_cycles", obs_rw, 1);
      chk("lw_count", exp_count, 1);

      // sw held 3 cycles in MEM_WRITE
      stall_left = 3;
      run_instr(OP_SW, 1'b0, 2);
      chk("sw_memwrite_cycles", obs_mw, 4);
      chk("sw_cycles", cyc, 7);

      // beq taken and not taken both pulse pc_write_cond
      cnt_before = exp_count;
      run_instr(OP_BEQ, 1'b1, 0);
      chk("beq1_pcc", obs_pcc, 1);
      chk("beq1_cycles", cyc, 3);
      run_instr(OP_BEQ, 1'b0, 0);
      chk("beq0_pcc", obs_pcc, 1);
      chk("beq0_cycles", cyc, 3);
      chk("beq_count", exp_count - cnt_before, 2);

      run_instr(OP_RTYPE, 1'b0, 0);
      run_instr(OP_ADDI, 1'b0, 0);

      // undecoded opcode
      cnt_before = exp_count;
      run_instr(6'b111111, 1'b0, 0);
      chk("ill_pulses", obs_ill, 1);
      chk("ill_count", exp_count, cnt_before);
      chk("ill_wr", obs_rw + obs_mw, 0);

      // asynchronous reset in the middle of a stalled lw read
      begin_instr(OP_LW, 1'b0);
      step_cycle(1'b1); step_cycle(1'b1); step_cycle(1'b1); step_cycle(1'b0);
      #2;
      mem_ready = 1'b1; Rst = 1'b1;
      #1;
      check_reset_outputs("arst0");
      @(posedge Clk); #1;
      check_reset_outputs("arst1");
      chk("arst_regwrite", obs_rw, 0);
      @(negedge Clk);
      Rst = 1'b0; mem_ready = 1'b0;
      exp_count = 32'd0;
      run_instr(OP_ADDI, 1'b0, 0);

      // wrap of the retired-instruction counter on a jump
      begin_instr(OP_J, 1'b0);
      step_cycle(1'b0);
      force dut.instr_count_q = 32'hFFFF_FFFF;
      #1;
      release dut.instr_count_q;
      exp_count = 32'hFFFF_FFFF;
      finish_instr(0);
      chk("j_cycles", cyc, 4);
      begin_instr(OP_RTYPE, 1'b0);
      step_cycle(1'b1);
      chk("wrap_count", instr_count, 32'd0);
      finish_instr(0);

      // random instruction stream with random memory wait states
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 6))
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_RTYPE;
            3: op = OP_BEQ;
            4: op = OP_J;
            5: op = OP_ADDI;
            default: op = 6'($urandom_range(0, 63));
         endcase
         run_instr(op, 1'($urandom_range(0, 1)), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL expose exactly these ports, clock and reset first:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous reset, active high.
- opcode  in  6  instr[31:26], taken from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero=1.
- i_or_d  out  1  memory address source: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  instruction register load.
- mem_to_reg  out  1  register write data: 0=ALUOut, 1=MDR.
- reg_dst  out  1  write register: 0=rt, 1=rd.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A input: 0=PC, 1=rs.
- alu_src_b  out  2  ALU B input: 00=rt, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- alu_op  out  3  to ALU_CTRL: 000=add, 001=sub, 010=decode funct.
- pc_source  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- state  out  4  current state encoding.
- illegal_op  out  1  one-cycle pulse on an undecoded opcode.
- instr_count  out  32  count of retired instructions.

Function
REQ-003 The FSM SHALL have these states and encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EXEC=10, ADDI_WB=11. Encodings 12-15 SHALL return to FETCH on the next edge.
REQ-004 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=000 and pc_source=00.
- ir_write=1 and pc_write=1 SHALL assert only in a cycle with mem_ready=1.
- The FSM SHALL stay in FETCH while mem_ready=0 and go to DECODE when mem_ready=1.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=000, and SHALL dispatch on opcode:
- 100011 (lw) or 101011 (sw) -> MEM_ADDR.
- 000000 (R-type) -> EXECUTE.
- 000100 (beq) -> BRANCH.
- 000010 (j) -> JUMP.
- 001000 (addi) -> ADDI_EXEC.
- Any other opcode -> FETCH, with illegal_op=1 for one cycle and no increment of instr_count.
REQ-006 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000, then go to MEM_READ for lw and MEM_WRITE for sw.
REQ-007 MEM_READ SHALL drive mem_read=1 and i_or_d=1, hold while mem_ready=0, and go to MEM_WB on mem_ready=1.
REQ-008 MEM_WB SHALL drive reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-009 MEM_WRITE SHALL drive mem_write=1 and i_or_d=1, hold while mem_ready=0, and go to FETCH on mem_ready=1.
- mem_write SHALL stay at 1 for the entire hold.
REQ-010 EXECUTE SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=010, then go to R_WB.
- R_WB SHALL drive reg_write=1, reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-011 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1 and pc_source=01, then go to FETCH.
REQ-012 JUMP SHALL drive pc_write=1 and pc_source=10, then go to FETCH.
REQ-013 ADDI_EXEC SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=000, then go to ADDI_WB.
- ADDI_WB SHALL drive reg_write=1, reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-014 Every output not listed for a state SHALL be 0.
- No two of reg_write, mem_write and ir_write SHALL be 1 in the same cycle.
REQ-015 instr_count SHALL increment by 1 on the final edge of each instruction. The final edges are the exits of MEM_WB, MEM_WRITE (with mem_ready=1), R_WB, BRANCH, JUMP and ADDI_WB.
- instr_count SHALL wrap from 0xFFFFFFFF to 0.
REQ-016 Instruction latencies with mem_ready held at 1 SHALL be:
- lw: 5 cycles.
- sw, R-type, addi: 4 cycles.
- beq, j: 3 cycles.
- Each cycle of mem_ready=0 SHALL add exactly one cycle.

Reset
REQ-017 Rst=1 SHALL immediately set state=FETCH, instr_count=0 and illegal_op=0, independent of Clk.
REQ-018 While Rst=1, pc_write, pc_write_cond, ir_write, reg_write and mem_write SHALL be forced to 0.
REQ-019 Rst asserted mid-instruction SHALL abort it with no further write strobes and no instr_count increment. The first cycle after deassertion SHALL be FETCH.

Verification
REQ-020 lw (opcode 100011), mem_ready=1 -> state 0,1,2,3,4,0; reg_write=1 only in state 4; instr_count 0->1.
REQ-021 sw with mem_ready=0 for 3 cycles in MEM_WRITE -> mem_write=1 for 4 consecutive cycles; state returns to 0; total 7 cycles.
REQ-022 beq with zero=1, then beq with zero=0 -> pc_write_cond=1 in state 8 in both cases; each takes 3 cycles; instr_count=2.
REQ-023 opcode 111111 -> illegal_op pulses 1 cycle in DECODE; next state 0; instr_count unchanged; no write strobes.
REQ-024 Rst pulsed in the MEM_READ hold (mem_ready=0) -> state=0 immediately without a clock edge; instr_count=0; reg_write never asserted.
REQ-025 instr_count preset to 0xFFFFFFFF, then one j (000010) -> instr_count=0 after 3 cycles; pc_write=1 with pc_source=10 in state 9.
